// File: rtl/decode_stage_p.sv
// decode_stage_p: decode stage with register bank, valid/ready handshake, flush and load-use stall
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/ir         : instruction from fetch
//   flush                        : kill held and incoming instruction
//   wr_en/wr_addr/wr_data        : writeback into the register bank
//   out_valid/out_ready          : handshake toward execute
//   op, a_out, b_out, imm_out,
//   addr_d_out                   : registered decoded fields and operands
//   read_mmu, write_mmu,
//   byte_select_mmu              : registered memory-access controls
//
// Optional feature: define BYPASS_EN so a same-cycle writeback feeds the captured operands.
module decode_stage_p #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int IMM_W    = 15,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     ir,
   input  logic            flush,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [6:0]      op,
   output logic [XLEN-1:0] a_out,
   output logic [XLEN-1:0] b_out,
   output logic [XLEN-1:0] imm_out,
   output logic [AW-1:0]   addr_d_out,
   output logic            read_mmu,
   output logic            write_mmu,
   output logic            byte_select_mmu
);
   localparam logic [6:0] LDW = 7'h11, LDB = 7'h12, STW = 7'h13, STB = 7'h14;
   logic [XLEN-1:0] bank_q [NREGS];
   logic            zr, wr_ok, adv, hazard, cap;
   logic [6:0]      opc;
   logic [AW-1:0]   ra, rb, rd;
   logic [XLEN-1:0] a_rd, b_rd, imm_ext;
   logic            valid_q, valid_d, rmmu_q, rmmu_d, wmmu_q, wmmu_d, bsel_q, bsel_d;
   logic [6:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
   logic [AW-1:0]   rd_q, rd_d;

   assign zr      = (ZERO_REG != 0);
   assign opc     = ir[31:25];
   assign rd      = AW'(ir[24:20]);
   assign ra      = AW'(ir[19:15]);
   assign rb      = AW'(ir[14:10]);
   assign imm_ext = XLEN'($signed(ir[IMM_W-1:0]));
   assign wr_ok   = wr_en & ~(zr & (wr_addr == '0));

`ifdef BYPASS_EN
   // wr_ok already excludes r0 when it is hardwired, so r0 is never bypassed
   assign a_rd = (wr_ok && wr_addr == ra) ? wr_data : bank_q[ra];
   assign b_rd = (wr_ok && wr_addr == rb) ? wr_data : bank_q[rb];
`else
   assign a_rd = bank_q[ra];
   assign b_rd = bank_q[rb];
`endif

   // a load in the output register whose destination is a source of the incoming ir
   // must let one bubble pass so execute can forward the loaded value
   assign adv      = ~valid_q | out_ready;
   assign hazard   = valid_q & rmmu_q & in_valid & ((ra == rd_q) | (rb == rd_q)) & ~(zr & (rd_q == '0));
   assign in_ready = flush | (adv & ~hazard);
   assign cap      = ~flush & adv & ~hazard & in_valid;

   always_comb begin
      valid_d = flush ? 1'b0 : (adv ? (in_valid & ~hazard) : valid_q);
      op_d    = cap ? opc : op_q;
      a_d     = cap ? a_rd : a_q;
      b_d     = cap ? b_rd : b_q;
      imm_d   = cap ? imm_ext : imm_q;
      rd_d    = cap ? rd : rd_q;
      rmmu_d  = cap ? (opc == LDW || opc == LDB) : rmmu_q;
      wmmu_d  = cap ? (opc == STW || opc == STB) : wmmu_q;
      bsel_d  = cap ? (opc == LDB || opc == STB) : bsel_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) bank_q[i] <= '0;
      end else if (wr_ok) begin
         bank_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         rd_q    <= '0;
         rmmu_q  <= 1'b0;
         wmmu_q  <= 1'b0;
         bsel_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         imm_q   <= imm_d;
         rd_q    <= rd_d;
         rmmu_q  <= rmmu_d;
         wmmu_q  <= wmmu_d;
         bsel_q  <= bsel_d;
      end
   end

   assign out_valid       = valid_q;
   assign op              = op_q;
   assign a_out           = a_q;
   assign b_out           = b_q;
   assign imm_out         = imm_q;
   assign addr_d_out      = rd_q;
   assign read_mmu        = rmmu_q;
   assign write_mmu       = wmmu_q;
   assign byte_select_mmu = bsel_q;
endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed and random checks of decode_stage_p against a transaction-level model
module tb_decode_stage_p;
   logic        clk = 1'b0, reset = 1'b0;
   logic        in_valid = 1'b0, flush = 1'b0, wr_en = 1'b0, out_ready = 1'b0;
   logic [31:0] ir = '0, wr_data = '0;
   logic [4:0]  wr_addr = '0;
   logic        in_ready, out_valid, read_mmu, write_mmu, byte_select_mmu;
   logic [6:0]  op;
   logic [31:0] a_out, b_out, imm_out;
   logic [4:0]  addr_d_out;
   int          total = 0, bad = 0;

`ifdef BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // model state: register file contents and what execute should currently see
   logic [31:0] m_bank [32];
   logic        e_valid, e_rm, e_wm, e_bs;
   logic [6:0]  e_op;
   logic [31:0] e_a, e_b, e_imm;
   logic [4:0]  e_rd;

   decode_stage_p dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .ir(ir),
      .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .out_valid(out_valid), .out_ready(out_ready), .op(op), .a_out(a_out), .b_out(b_out),
      .imm_out(imm_out), .addr_d_out(addr_d_out), .read_mmu(read_mmu), .write_mmu(write_mmu),
      .byte_select_mmu(byte_select_mmu)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic chk_out();
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("op", 32'(op), 32'(e_op));
      chk("a_out", a_out, e_a);
      chk("b_out", b_out, e_b);
      chk("imm_out", imm_out, e_imm);
      chk("addr_d_out", 32'(addr_d_out), 32'(e_rd));
      chk("read_mmu", 32'(read_mmu), 32'(e_rm));
      chk("write_mmu", 32'(write_mmu), 32'(e_wm));
      chk("byte_select_mmu", 32'(byte_select_mmu), 32'(e_bs));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_bank[i] = '0;
      {e_valid, e_rm, e_wm, e_bs, e_op, e_a, e_b, e_imm, e_rd} = '0;
   endtask

   function automatic logic [31:0] mk(input logic [6:0] o, input logic [4:0] d, input logic [4:0] a,
                                      input logic [4:0] b, input logic [9:0] lo);
      return {o, d, a, b, lo};
   endfunction

   // operand as seen at capture time: old contents unless bypass forwards the same-cycle write
   function automatic logic [31:0] rdreg(input logic [4:0] r, input logic we, input logic [4:0] wa,
                                         input logic [31:0] wd);
      return (BYP && we && wa == r && r != 0) ? wd : m_bank[r];
   endfunction

   // called just after a rising edge: drive one cycle of inputs, check in_ready, predict, check outputs
   task automatic cyc(input logic iv, input logic [31:0] i, input logic fl, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic ordy);
      logic [4:0] ra, rb;
      logic       adv, hz, cap;
      in_valid = iv; ir = i; flush = fl; wr_en = we; wr_addr = wa; wr_data = wd; out_ready = ordy;
      ra  = i[19:15];
      rb  = i[14:10];
      adv = !e_valid || ordy;
      hz  = e_valid && e_rm && iv && (ra == e_rd || rb == e_rd) && e_rd != 0;
      #1 chk("in_ready", 32'(in_ready), 32'(fl || (adv && !hz)));
      cap = !fl && adv && !hz && iv;
      if (fl) e_valid = 1'b0;
      else if (adv) e_valid = cap;
      if (cap) begin
         e_op  = i[31:25];
         e_a   = rdreg(ra, we, wa, wd);
         e_b   = rdreg(rb, we, wa, wd);
         e_imm = 32'($signed(i[14:0]));
         e_rd  = i[24:20];
         e_rm  = (e_op == 7'h11 || e_op == 7'h12);
         e_wm  = (e_op == 7'h13 || e_op == 7'h14);
         e_bs  = (e_op == 7'h12 || e_op == 7'h14);
      end
      if (we && wa != 0) m_bank[wa] = wd;
      @(posedge clk);
      #1 chk_out();
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 chk_out();
      reset = 1'b1;
      // write r5 then read it with rb=r0
      cyc(0, '0, 0, 1, 5'd5, 32'hDEADBEEF, 1);
      cyc(1, mk(7'h00, 5'd1, 5'd5, 5'd0, 10'h0), 0, 0, 0, 0, 1);
      chk("t2_a", a_out, 32'hDEADBEEF);
      chk("t2_b", b_out, 32'h0);
      // r0 write ignored, r7 preset, then same-cycle write of r7 during capture
      cyc(0, '0, 0, 1, 5'd0, 32'h12345678, 1);
      cyc(0, '0, 0, 1, 5'd7, 32'h11, 1);
      cyc(1, mk(7'h00, 5'd2, 5'd7, 5'd0, 10'h0), 0, 1, 5'd7, 32'h55, 1);
      chk("t5_a", a_out, BYP ? 32'h55 : 32'h11);
      // load-use: LDW rd=3 then a consumer of r3 stalls exactly one cycle
      cyc(1, mk(7'h11, 5'd3, 5'd5, 5'd0, 10'h0), 0, 0, 0, 0, 1);
      cyc(1, mk(7'h00, 5'd4, 5'd3, 5'd0, 10'h0), 0, 0, 0, 0, 1);
      chk("t3_bubble", 32'(out_valid), 32'h0);
      cyc(1, mk(7'h00, 5'd4, 5'd3, 5'd0, 10'h0), 0, 0, 0, 0, 1);
      chk("t3_capture", 32'(addr_d_out), 32'd4);
      // backpressure for three cycles, then flush while held
      cyc(1, mk(7'h13, 5'd6, 5'd5, 5'd7, 10'h3), 0, 0, 0, 0, 1);
      repeat (3) cyc(1, mk(7'h00, 5'd8, 5'd1, 5'd1, 10'h0), 0, 0, 0, 0, 0);
      cyc(1, mk(7'h00, 5'd8, 5'd1, 5'd1, 10'h0), 1, 0, 0, 0, 0);
      // negative immediate with STB
      cyc(1, mk(7'h14, 5'd1, 5'd2, 5'h10, 10'h0), 0, 0, 0, 0, 1);
      chk("t6_imm", imm_out, 32'hFFFFC000);
      chk("t6_wm", 32'(write_mmu), 32'h1);
      chk("t6_bs", 32'(byte_select_mmu), 32'h1);
      chk("t6_rm", 32'(read_mmu), 32'h0);
      // random traffic with small register indices so hazards and bypasses occur often
      for (int n = 0; n < 400; n++) begin
         logic [6:0] o;
         int         k;
         k = $urandom_range(0, 5);
         o = (k < 4) ? 7'(7'h11 + k) : 7'($urandom);
         cyc($urandom_range(0, 3) != 0,
             mk(o, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 10'($urandom)),
             $urandom_range(0, 15) == 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 3) != 0);
      end
      // mid-stream asynchronous reset while holding a valid instruction
      cyc(0, '0, 0, 1, 5'd5, 32'hCAFEF00D, 1);
      cyc(1, mk(7'h12, 5'd2, 5'd5, 5'd5, 10'h1), 0, 0, 0, 0, 1);
      chk("rst_pre_valid", 32'(out_valid), 32'h1);
      reset = 1'b0;
      #1;
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_a", a_out, 32'h0);
      chk("rst_b", b_out, 32'h0);
      chk("rst_op", 32'(op), 32'h0);
      model_reset();
      chk_out();
      @(posedge clk);
      #1 reset = 1'b1;
      cyc(1, mk(7'h00, 5'd1, 5'd5, 5'd7, 10'h0), 0, 0, 0, 0, 1);
      chk("rst_bank_a", a_out, 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
